div_arbiter: RTL and testbench
==============================

// Module: div_arbiter
// PURPOSE
//  Owns the single shared divider of the bicycle computer and time-shares it between the
//  speed requester (port 0) and the average-speed requester (port 1).
//  Grants one requester at a time. Drives the divider's Select and en inputs and
//  waits for Ready. Returns the registered quotient with a one-cycle done pulse.
//  Short-circuits divide-by-zero; optional watchdog aborts a hung divider.
// PARAMETERS
//  DIV_WIDTH       12   quotient width (divider Res)
//  IN_WIDTH        16   divisor width, used for the zero check only
//  TIMEOUT_CYCLES  64   watchdog limit in WAIT cycles (used only with DIV_ARB_WATCHDOG_EN)
// PORTS
//  clock        in   1          system clock, rising edge
//  reset        in   1          asynchronous, active-low
//  spd_req      in   1          speed requests a division; level, held until spd_done
//  spd_divisor  in   IN_WIDTH   speed divisor; stable while spd_grant=1
//  avg_req      in   1          average-speed request; level, held until avg_done
//  avg_divisor  in   IN_WIDTH   average-speed divisor; stable while avg_grant=1
//  div_ready    in   1          divider result valid (pulse or level)
//  div_res      in   DIV_WIDTH  divider quotient
//  div_select   out  1          0 = Dividend1/Divisor1 (speed), 1 = Dividend2/Divisor2 (avg)
//  div_en       out  1          divider start, one-cycle pulse
//  spd_grant    out  1          speed owns the divider
//  avg_grant    out  1          average-speed owns the divider
//  spd_done     out  1          one-cycle pulse: result valid for speed
//  avg_done     out  1          one-cycle pulse: result valid for avg
//  result       out  DIV_WIDTH  registered quotient; held until the next DONE
//  div_zero     out  1          pulses with done when the divisor was 0
//  timeout      out  1          pulses with done when the watchdog fired
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, last_owner=avg, all outputs 0, result=0.
//  FSM: IDLE -> SETUP -> LAUNCH -> WAIT -> DONE -> IDLE.
//   IDLE: samples spd_req and avg_req.
//     - Only one high: that requester wins.
//     - Both high: the port other than last_owner wins (alternating; speed first after reset).
//     - Registers owner, div_select and the owner's grant -> SETUP.
//   SETUP: select and grant are stable.
//     - Owner's divisor==0: result<=all-ones, div_zero flag set -> DONE; div_en is never raised.
//     - Otherwise -> LAUNCH.
//   LAUNCH: div_en=1 for exactly this cycle -> WAIT.
//   WAIT: div_en=0; div_ready is not sampled in LAUNCH.
//     - On div_ready=1: result<=div_res -> DONE.
//   DONE: owner's done=1 and div_zero/timeout reflect the flags, all for exactly this cycle.
//     - Grant drops at the end of DONE; last_owner<=owner -> IDLE.
//  div_select and grant are held constant from SETUP through DONE.
//  The non-owner's req is ignored until IDLE.
//  Latency, req seen in IDLE at cycle 0 and Ready first high at cycle k>=3: done at cycle k+1.
//  Minimum latency with a zero divisor: done at cycle 2.
//  Requester contract: drop req at the edge after done. A req still high in IDLE is a new request.
//  If req deasserts mid-operation, the operation still completes and done still pulses.
//  No request is lost: a pending loser is served immediately after the current DONE.
//  div_busy is not used; Ready alone terminates WAIT.
// CONFIGURATION
//  DIV_ARB_WATCHDOG_EN defined:
//   - WAIT counts cycles from 1.
//   - At count==TIMEOUT_CYCLES without div_ready: result<=all-ones, timeout flag set -> DONE.
//   - The counter clears in IDLE.
//  Not defined: WAIT waits indefinitely; timeout is tied 0 and there is no counter logic.
// TESTING
//  1. Speed only, divisor=20, divider returns 180 (0x0B4) 5 cycles after en
//     -> spd_done 1 cycle later, result=180, avg_done=0.
//  2. spd_req and avg_req rise in the same cycle after reset
//     -> speed served first (div_select=0), then avg (div_select=1); exactly one div_en each.
//  3. avg_divisor=0 -> div_en stays 0; avg_done and div_zero pulse together; result=0xFFF.
//  4. Watchdog build, TIMEOUT_CYCLES=64, div_ready never asserted
//     -> timeout and spd_done at WAIT count 64; result=0xFFF; next request proceeds normally.
//  5. reset=0 during WAIT -> all outputs 0 immediately.
//     After release with avg_req high -> avg granted, since last_owner=avg resets to speed-first only when both request.
//  6. Continuous spd_req and avg_req for 10 operations -> owners alternate, none starved.

Source files
------------

// File: rtl/div_arbiter_if.sv
// Bundle of requester-side and divider-side signals around the shared divider arbiter.
// master: the arbiter; slave: requesters plus the divider.
interface div_arbiter_if #(
    parameter int unsigned DIV_WIDTH = 12,
    parameter int unsigned IN_WIDTH  = 16
);
    logic                 spd_req;
    logic [IN_WIDTH-1:0]  spd_divisor;
    logic                 avg_req;
    logic [IN_WIDTH-1:0]  avg_divisor;
    logic                 div_ready;
    logic [DIV_WIDTH-1:0] div_res;
    logic                 div_select;
    logic                 div_en;
    logic                 spd_grant;
    logic                 avg_grant;
    logic                 spd_done;
    logic                 avg_done;
    logic [DIV_WIDTH-1:0] result;
    logic                 div_zero;
    logic                 timeout;

    modport master (
        input  spd_req, spd_divisor, avg_req, avg_divisor, div_ready, div_res,
        output div_select, div_en, spd_grant, avg_grant, spd_done, avg_done, result,
               div_zero, timeout
    );

    modport slave (
        output spd_req, spd_divisor, avg_req, avg_divisor, div_ready, div_res,
        input  div_select, div_en, spd_grant, avg_grant, spd_done, avg_done, result,
               div_zero, timeout
    );
endinterface

// File: rtl/div_arbiter.sv
// Time-shares one divider between the speed (port 0) and average-speed (port 1) requesters.
// Define DIV_ARB_WATCHDOG_EN to abort a WAIT that exceeds TIMEOUT_CYCLES.
module div_arbiter #(
    parameter int unsigned DIV_WIDTH      = 12,
    parameter int unsigned IN_WIDTH       = 16
`ifdef DIV_ARB_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input logic           clk_i,
    input logic           rst_ni,
    div_arbiter_if.master bus
);

    typedef enum logic [2:0] {StIdle, StSetup, StLaunch, StWait, StDone} state_e;

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;  // 0 = speed, 1 = average
    logic                 last_q, last_d;
    logic [DIV_WIDTH-1:0] result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 divisor_zero;

`ifdef DIV_ARB_WATCHDOG_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            tmo_q, tmo_d;

    assign cnt_inc     = cnt_q + CntW'(1);
    assign bus.timeout = (state_q == StDone) && tmo_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign divisor_zero = owner_q ? (bus.avg_divisor == '0) : (bus.spd_divisor == '0);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef DIV_ARB_WATCHDOG_EN
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
`endif
        unique case (state_q)
            StIdle: begin
                zero_d = 1'b0;
`ifdef DIV_ARB_WATCHDOG_EN
                cnt_d  = '0;
                tmo_d  = 1'b0;
`endif
                // Contention goes to whichever port did not own the previous operation.
                if (bus.spd_req && bus.avg_req) begin
                    owner_d = ~last_q;
                    state_d = StSetup;
                end else if (bus.spd_req) begin
                    owner_d = 1'b0;
                    state_d = StSetup;
                end else if (bus.avg_req) begin
                    owner_d = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (divisor_zero) begin
                    result_d = '1;
                    zero_d   = 1'b1;
                    state_d  = StDone;
                end else begin
                    state_d  = StLaunch;
                end
            end
            StLaunch: state_d = StWait;
            StWait: begin
`ifdef DIV_ARB_WATCHDOG_EN
                cnt_d = cnt_inc;
`endif
                if (bus.div_ready) begin
                    result_d = bus.div_res;
                    state_d  = StDone;
                end
`ifdef DIV_ARB_WATCHDOG_EN
                else if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
                    result_d = '1;
                    tmo_d    = 1'b1;
                    state_d  = StDone;
                end
`endif
            end
            StDone: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef DIV_ARB_WATCHDOG_EN
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef DIV_ARB_WATCHDOG_EN
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign bus.div_select = owner_q;
    assign bus.div_en     = (state_q == StLaunch);
    assign bus.spd_grant  = (state_q != StIdle) && !owner_q;
    assign bus.avg_grant  = (state_q != StIdle) && owner_q;
    assign bus.spd_done   = (state_q == StDone) && !owner_q;
    assign bus.avg_done   = (state_q == StDone) && owner_q;
    assign bus.div_zero   = (state_q == StDone) && zero_q;
    assign bus.result     = result_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: randomized divider delays/quotients against an
// arbitration/latency model derived from the request rules.
module tb_div_arbiter;
    localparam int DW = 12;
    localparam int IW = 16;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_arbiter_if #(.DIV_WIDTH(DW), .IN_WIDTH(IW)) bus ();

    div_arbiter #(.DIV_WIDTH(DW), .IN_WIDTH(IW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int en_count = 0;
    bit hang = 1'b0;
    int dly = 1;
    logic [DW-1:0] res_val = '0;
    bit model_last = 1'b1;

    // Divider stand-in: ready pulses dly cycles after the en cycle, unless hung.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.div_en === 1'b1) begin
                en_count++;
                if (!hang) begin
                    repeat (dly) @(posedge clk);
                    #1;
                    bus.div_ready = 1'b1;
                    bus.div_res   = res_val;
                    @(posedge clk);
                    #1;
                    bus.div_ready = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic bit pick(bit s, bit a);
        if (s && a) return !model_last;
        return a;
    endfunction

    function automatic logic [6:0] flags_exp(bit owner, bit zero, bit tmo);
        return {!owner, owner, !owner, owner, owner, zero, tmo};
    endfunction

    function automatic logic [6:0] flags_obs();
        return {bus.spd_done, bus.avg_done, bus.spd_grant, bus.avg_grant, bus.div_select,
                bus.div_zero, bus.timeout};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(bus.spd_done === 1'b1 || bus.avg_done === 1'b1) && n < 200);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.spd_req = 1'b0;
        bus.avg_req = 1'b0;
        bus.spd_divisor = '0;
        bus.avg_divisor = '0;
        bus.div_ready = 1'b0;
        bus.div_res = '0;
        hang = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        model_last = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        step();
        n_cmp++;
        if (flags_obs() !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want %b", flags_obs(), 7'b0);
        end
        n_cmp++;
        if ({bus.div_en, bus.result} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_en_result: got %h want 0", {bus.div_en, bus.result});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_speed_only();
        int n, e0;
        bit o;
        dly = 5;
        res_val = 12'd180;
        bus.spd_divisor = 16'd20;
        e0 = en_count;
        bus.spd_req = 1'b1;
        o = pick(1'b1, 1'b0);
        wait_done(n);
        n_cmp++;
        if (flags_obs() !== flags_exp(o, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL spd_flags: got %b want %b", flags_obs(), flags_exp(o, 1'b0, 1'b0));
        end
        n_cmp++;
        if (bus.result !== 12'd180) begin
            n_fail++;
            $display("FAIL spd_result: got %0d want 180", bus.result);
        end
        n_cmp++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL spd_latency: got %0d want 8", n);
        end
        n_cmp++;
        if (en_count - e0 != 1) begin
            n_fail++;
            $display("FAIL spd_en_count: got %0d want 1", en_count - e0);
        end
        model_last = o;
        step();
        bus.spd_req = 1'b0;
    endtask

    task automatic test_both_first();
        int n, e0;
        bit o;
        logic [DW-1:0] r;
        do_reset();
        bus.spd_divisor = 16'($urandom_range(65535, 1));
        bus.avg_divisor = 16'($urandom_range(65535, 1));
        e0 = en_count;
        for (int k = 0; k < 2; k++) begin
            dly = $urandom_range(6, 1);
            res_val = 12'($urandom);
            r = res_val;
            if (k == 0) begin
                bus.spd_req = 1'b1;
                bus.avg_req = 1'b1;
            end
            o = pick(bus.spd_req, bus.avg_req);
            wait_done(n);
            n_cmp++;
            if (flags_obs() !== flags_exp(o, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL both%0d_flags: got %b want %b", k, flags_obs(),
                         flags_exp(o, 1'b0, 1'b0));
            end
            n_cmp++;
            if (bus.result !== r || n != 3 + dly) begin
                n_fail++;
                $display("FAIL both%0d_result_lat: got %h/%0d want %h/%0d", k, bus.result, n,
                         r, 3 + dly);
            end
            n_cmp++;
            if (en_count - e0 != k + 1) begin
                n_fail++;
                $display("FAIL both%0d_en_count: got %0d want %0d", k, en_count - e0, k + 1);
            end
            model_last = o;
            step();
            if (o == 1'b0) bus.spd_req = 1'b0;
            else bus.avg_req = 1'b0;
        end
    endtask

    task automatic test_zero_divisor();
        int n, e0;
        bit o;
        bus.avg_divisor = '0;
        e0 = en_count;
        bus.avg_req = 1'b1;
        o = pick(1'b0, 1'b1);
        wait_done(n);
        n_cmp++;
        if (flags_obs() !== flags_exp(o, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL zero_flags: got %b want %b", flags_obs(), flags_exp(o, 1'b1, 1'b0));
        end
        n_cmp++;
        if (bus.result !== 12'hFFF || n != 2) begin
            n_fail++;
            $display("FAIL zero_result_lat: got %h/%0d want fff/2", bus.result, n);
        end
        n_cmp++;
        if (en_count != e0) begin
            n_fail++;
            $display("FAIL zero_no_en: got %0d want %0d", en_count, e0);
        end
        model_last = o;
        step();
        bus.avg_req = 1'b0;
    endtask

`ifdef DIV_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        hang = 1'b1;
        bus.spd_divisor = 16'd7;
        bus.spd_req = 1'b1;
        wait_done(n);
        n_cmp++;
        if (flags_obs() !== flags_exp(1'b0, 1'b0, 1'b1) || n != 3 + TO) begin
            n_fail++;
            $display("FAIL wdog_flags_lat: got %b/%0d want %b/%0d", flags_obs(), n,
                     flags_exp(1'b0, 1'b0, 1'b1), 3 + TO);
        end
        n_cmp++;
        if (bus.result !== 12'hFFF) begin
            n_fail++;
            $display("FAIL wdog_result: got %h want fff", bus.result);
        end
        model_last = 1'b0;
        step();
        hang = 1'b0;
        dly = 2;
        res_val = 12'h5A5;
        wait_done(n);
        n_cmp++;
        if (flags_obs() !== flags_exp(1'b0, 1'b0, 1'b0) || bus.result !== 12'h5A5) begin
            n_fail++;
            $display("FAIL wdog_recover: got %b/%h want %b/5a5", flags_obs(), bus.result,
                     flags_exp(1'b0, 1'b0, 1'b0));
        end
        step();
        bus.spd_req = 1'b0;
    endtask
`endif

    task automatic test_reset_in_wait();
        int n;
        hang = 1'b1;
        bus.spd_divisor = 16'd5;
        bus.spd_req = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (flags_obs() !== 7'b0) begin
            n_fail++;
            $display("FAIL rstwait_flags: got %b want %b", flags_obs(), 7'b0);
        end
        n_cmp++;
        if ({bus.div_en, bus.result} !== 13'b0) begin
            n_fail++;
            $display("FAIL rstwait_en_result: got %h want 0", {bus.div_en, bus.result});
        end
        bus.spd_req = 1'b0;
        bus.avg_req = 1'b1;
        bus.avg_divisor = 16'($urandom_range(65535, 1));
        hang = 1'b0;
        dly = $urandom_range(5, 1);
        res_val = 12'($urandom);
        step();
        rst_n = 1'b1;
        model_last = 1'b1;
        wait_done(n);
        n_cmp++;
        if (flags_obs() !== flags_exp(1'b1, 1'b0, 1'b0) || bus.result !== res_val) begin
            n_fail++;
            $display("FAIL rstwait_avg: got %b/%h want %b/%h", flags_obs(), bus.result,
                     flags_exp(1'b1, 1'b0, 1'b0), res_val);
        end
        n_cmp++;
        if (n != 3 + dly) begin
            n_fail++;
            $display("FAIL rstwait_latency: got %0d want %0d", n, 3 + dly);
        end
        model_last = 1'b1;
        step();
        bus.avg_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n, spd_served, exp_n;
        bit o, z;
        logic [DW-1:0] r;
        do_reset();
        spd_served = 0;
        bus.spd_divisor = ($urandom_range(3, 0) == 0) ? 16'd0 : 16'($urandom_range(65535, 1));
        bus.avg_divisor = ($urandom_range(3, 0) == 0) ? 16'd0 : 16'($urandom_range(65535, 1));
        dly = $urandom_range(8, 1);
        res_val = 12'($urandom);
        bus.spd_req = 1'b1;
        bus.avg_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            o = pick(1'b1, 1'b1);
            z = (o ? bus.avg_divisor : bus.spd_divisor) == '0;
            r = z ? 12'hFFF : res_val;
            exp_n = z ? 2 : 3 + dly;
            wait_done(n);
            if (bus.spd_done === 1'b1) spd_served++;
            n_cmp++;
            if (flags_obs() !== flags_exp(o, z, 1'b0)) begin
                n_fail++;
                $display("FAIL b2b%0d_flags: got %b want %b", i, flags_obs(),
                         flags_exp(o, z, 1'b0));
            end
            n_cmp++;
            if (bus.result !== r || n != exp_n) begin
                n_fail++;
                $display("FAIL b2b%0d_result_lat: got %h/%0d want %h/%0d", i, bus.result, n,
                         r, exp_n);
            end
            model_last = o;
            step();
            if (o) bus.avg_divisor = ($urandom_range(3, 0) == 0) ? 16'd0
                                                                 : 16'($urandom_range(65535, 1));
            else bus.spd_divisor = ($urandom_range(3, 0) == 0) ? 16'd0
                                                              : 16'($urandom_range(65535, 1));
            dly = $urandom_range(8, 1);
            res_val = 12'($urandom);
        end
        n_cmp++;
        if (spd_served != 5) begin
            n_fail++;
            $display("FAIL b2b_fairness: got %0d speed ops want 5", spd_served);
        end
        bus.spd_req = 1'b0;
        bus.avg_req = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_speed_only();
        test_both_first();
        test_zero_divisor();
`ifdef DIV_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        test_reset_in_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
